// File: rtl/data_sram_slave_if.sv
// Data-side SRAM-like bus between the EX stage (master) and the memory responder (slave).
interface data_sram_slave_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Latency-modelling data SRAM responder: in-order pending queue, byte-strobe word memory.
// Define DSRAM_RAND_DELAY_EN to draw each response latency from an LFSR (1..DELAY).
module data_sram_slave #(
  parameter int ADDR_W = 10,
  parameter int DELAY  = 2,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_sram_slave_if.slave   bus
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] PTR_MAX = 2'(DEPTH - 1);

  logic [31:0]       r_mem [2**ADDR_W];
  logic [3:0]        r_vld;
  logic              r_wr    [4];
  logic [31:0]       r_rdata [4];
  logic [3:0]        r_cnt   [4];
  logic [1:0]        r_head;
  logic [1:0]        r_tail;
  logic [2:0]        r_count;

  logic              w_addr_ok;
  logic              w_accept;
  logic              w_data_ok;
  logic [ADDR_W-1:0] w_widx;
  logic [1:0]        w_head_nxt;
  logic [1:0]        w_tail_nxt;
  logic [3:0]        w_new_cnt;
  logic              w_unused;

  assign w_widx     = bus.data_sram_addr[ADDR_W+1:2];
  assign w_addr_ok  = !reset && (r_count < DEPTH_C);
  assign w_accept   = bus.data_sram_req && w_addr_ok;
  assign w_data_ok  = r_vld[r_head] && (r_cnt[r_head] == 4'd0);
  assign w_head_nxt = (r_head == PTR_MAX) ? 2'd0 : r_head + 2'd1;
  assign w_tail_nxt = (r_tail == PTR_MAX) ? 2'd0 : r_tail + 2'd1;
  assign w_unused   = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                        bus.data_sram_addr[1:0]};

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_new_cnt = 4'(r_lfsr[3:0] % 4'(DELAY));
`else
  assign w_new_cnt = 4'(DELAY - 1);
`endif

  // Memory is deliberately left out of reset so preloaded contents survive a flush.
  always_ff @(posedge clk) begin
    if (w_accept && bus.data_sram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b[1:0]]) begin
          r_mem[w_widx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_vld[i[1:0]] && (r_cnt[i[1:0]] != 4'd0)) begin
          r_cnt[i[1:0]] <= r_cnt[i[1:0]] - 4'd1;
        end
      end
      if (w_data_ok) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= w_head_nxt;
      end
      // The tail slot is never valid while accepting, so this load cannot collide with the countdown above.
      if (w_accept) begin
        r_vld[r_tail]   <= 1'b1;
        r_wr[r_tail]    <= bus.data_sram_wr;
        r_cnt[r_tail]   <= w_new_cnt;
        r_rdata[r_tail] <= bus.data_sram_wr ? '0 : r_mem[w_widx];
        r_tail          <= w_tail_nxt;
      end
      case ({w_accept, w_data_ok})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.data_sram_addr_ok = w_addr_ok;
  assign bus.data_sram_data_ok = w_data_ok;
  assign bus.data_sram_rdata   = (w_data_ok && !r_wr[r_head]) ? r_rdata[r_head] : '0;

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench for data_sram_slave; expected responses come from a reference memory.
module tb_data_sram_slave;

`ifdef DSRAM_RAND_DELAY_EN
  localparam int DELAY = 8;
`else
  localparam int DELAY = 2;
`endif
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  data_sram_slave_if bus();

  data_sram_slave #(.ADDR_W(10), .DELAY(DELAY), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        wr;
    int          t;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;
  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops and checks responses, then records any request accepted this cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] w;
    int          idx;
    int          lat;
    if (reset) begin
      sbq.delete();
    end else begin
      if (bus.data_sram_data_ok === 1'b1) begin
        vecs++;
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL spurious_data_ok: data_ok=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
        end else begin
          e = sbq.pop_front();
          if (bus.data_sram_rdata !== e.data) begin
            errs++;
            $display("FAIL rdata: got %h, required %h (wr=%0b, issued cycle %0d)",
                     bus.data_sram_rdata, e.data, e.wr, e.t);
          end
          vecs++;
          lat = cyc - e.t;
`ifdef DSRAM_RAND_DELAY_EN
          if (lat < 1 || lat > DELAY) begin
`else
          if (lat != DELAY) begin
`endif
            errs++;
            $display("FAIL latency: got %0d cycles, required %0d (upper bound in random mode)", lat, DELAY);
          end
          if (!e.wr) last_rd = bus.data_sram_rdata;
        end
      end
      if (bus.data_sram_req === 1'b1 && bus.data_sram_addr_ok === 1'b1) begin
        idx = int'(bus.data_sram_addr[11:2]);
        if (bus.data_sram_wr) begin
          w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.data_sram_wstrb[b]) w[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
          ref_mem[idx] = w;
          sbq.push_back('{data: 32'h0, wr: 1'b1, t: cyc});
        end else begin
          sbq.push_back('{data: (ref_mem.exists(idx) ? ref_mem[idx] : 32'hx), wr: 1'b0, t: cyc});
        end
      end
    end
  end

  task automatic idle();
    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
  endtask

  // Holds a request until accepted; returns just after the accepting edge with req still high.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    logic ok;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = wr;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_wstrb = strb;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = bus.data_sram_addr_ok;
      @(posedge clk); #1;
      if (ok === 1'b1) return;
    end
    vecs++;
    errs++;
    $display("FAIL accept_timeout: addr_ok=0 for 100 cycles, required 1");
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) return;
      @(posedge clk); #1;
    end
    vecs++;
    errs++;
    $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs += 2;
      if (bus.data_sram_addr_ok !== 1'b0) begin
        errs++; $display("FAIL reset_addr_ok: got %b, required 0", bus.data_sram_addr_ok);
      end
      if (bus.data_sram_data_ok !== 1'b0) begin
        errs++; $display("FAIL reset_data_ok: got %b, required 0", bus.data_sram_data_ok);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vecs += 3;
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errs++; $display("FAIL post_reset_addr_ok: got %b, required 1", bus.data_sram_addr_ok);
    end
    if (bus.data_sram_data_ok !== 1'b0) begin
      errs++; $display("FAIL post_reset_data_ok: got %b, required 0", bus.data_sram_data_ok);
    end
    if (bus.data_sram_rdata !== 32'h0) begin
      errs++; $display("FAIL post_reset_rdata: got %h, required 00000000", bus.data_sram_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    last_rd = '0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    idle();
    drain();
    vecs++;
    if (last_rd !== 32'hDEADBEEF) begin
      errs++; $display("FAIL write_read: got %h, required deadbeef", last_rd);
    end
  endtask

  task automatic test_byte_strobe();
    last_rd = '0;
    issue(1'b1, 32'h10, 32'h11223344, 4'hF);
    issue(1'b1, 32'h12 + (32'h1 << 12), 32'hAABBCCDD, 4'b0100);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    idle();
    drain();
    vecs++;
    if (last_rd !== 32'h11BB3344) begin
      errs++; $display("FAIL byte_strobe_wrap: got %h, required 11bb3344", last_rd);
    end
    last_rd = '0;
    issue(1'b1, 32'h14, 32'h55667788, 4'hF);
    issue(1'b1, 32'h16, 32'h0000CAFE, 4'b0011);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    idle();
    drain();
    vecs++;
    if (last_rd !== 32'h5566CAFE) begin
      errs++; $display("FAIL half_strobe: got %h, required 5566cafe", last_rd);
    end
  endtask

  task automatic test_full_queue();
    logic [3:0] exp_ok;
    logic [3:0] exp_dok;
    exp_ok  = 4'b1011;
    exp_dok = 4'b1100;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_addr  = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.data_sram_addr_ok !== exp_ok[i]) begin
        errs++; $display("FAIL full_addr_ok[%0d]: got %b, required %b", i, bus.data_sram_addr_ok, exp_ok[i]);
      end
`ifndef DSRAM_RAND_DELAY_EN
      vecs++;
      if (bus.data_sram_data_ok !== exp_dok[i]) begin
        errs++; $display("FAIL full_data_ok[%0d]: got %b, required %b", i, bus.data_sram_data_ok, exp_dok[i]);
      end
`endif
    end
    @(posedge clk); #1;
    idle();
    drain();
  endtask

  task automatic test_reset_flight();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.data_sram_data_ok !== 1'b0) begin
        errs++; $display("FAIL flush_data_ok: got %b at %0d cycles after reset, required 0",
                         bus.data_sram_data_ok, i);
      end
    end
    vecs += 2;
    if (dut.r_count !== 3'd0) begin
      errs++; $display("FAIL flush_count: got %0d, required 0", dut.r_count);
    end
    if (bus.data_sram_addr_ok !== 1'b1) begin
      errs++; $display("FAIL flush_addr_ok: got %b, required 1", bus.data_sram_addr_ok);
    end
    @(posedge clk); #1;
    last_rd = '0;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    idle();
    drain();
    vecs++;
    if (last_rd !== 32'h11BB3344) begin
      errs++; $display("FAIL mem_survives_reset: got %h, required 11bb3344", last_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 16; k++)
      issue(1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF);
    for (int n = 0; n < 200; n++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
          + (32'($urandom_range(0, 7)) << 12);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_byte_strobe();
`ifndef DSRAM_RAND_DELAY_EN
    test_full_queue();
`endif
    test_reset_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
